input_filter_ctrl: RTL and testbench
====================================

INPUT_FILTER_CTRL -- requirements
Module: input_filter_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of filtered input channels controlled.
REQ-002 Parameter FILTER_LOG, default 4: width of the filter window configuration.
REQ-003 Parameter PRESC_WIDTH, default 16: width of the sample prescaler.
REQ-004 Parameter DEFAULT_OUT, default 1: idle level of the filtered outputs.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 cfg_wr  in  1  one-cycle configuration write strobe.
REQ-008 cfg_conf  in  FILTER_LOG  requested filter window length.
REQ-009 cfg_presc  in  PRESC_WIDTH  requested sample prescaler value.
REQ-010 cfg_en  in  NUM_CH  requested per-channel filter enable.
REQ-011 cfg_busy  out  1  reconfiguration sequence in progress.
REQ-012 filt_conf  out  FILTER_LOG  window length driven to the filters.
REQ-013 filt_en  out  NUM_CH  per-channel enable driven to the filters.
REQ-014 sample_tick  out  1  one-cycle filter sample enable.
REQ-015 filt_out  in  NUM_CH  filtered channel levels returned from the filters.
REQ-016 irq_rise_en, irq_fall_en  in  NUM_CH each  per-channel edge interrupt enables.
REQ-017 irq_clr  in  NUM_CH  per-channel write-one-to-clear of the status bits.
REQ-018 irq_stat  out  NUM_CH  sticky per-channel edge status.
REQ-019 irq  out  1  OR of irq_stat.

Function
REQ-020 The FSM SHALL have states IDLE, DISABLE, APPLY, SETTLE and RUN.
REQ-021 cfg_wr SHALL be accepted only in IDLE or RUN; it latches cfg_conf, cfg_presc and cfg_en into shadow registers and moves to DISABLE on the next cycle.
REQ-022 cfg_wr in DISABLE, APPLY or SETTLE SHALL be ignored, with no shadow update.
REQ-023 DISABLE: the block SHALL drive filt_en all zero for exactly one cycle, then move to APPLY.
REQ-024 APPLY: filt_conf and the active prescaler SHALL load from the shadow, the prescaler counter and settle counter SHALL clear, and the FSM SHALL move to SETTLE if shadow enable is non-zero, otherwise to IDLE.
REQ-025 SETTLE: filt_en SHALL equal the shadow enable; the FSM SHALL move to RUN on the cycle after the filt_conf-th sample_tick, or on the cycle after APPLY when filt_conf is 0.
REQ-026 RUN: filt_en SHALL hold the shadow enable.
REQ-027 cfg_busy SHALL be 1 in DISABLE, APPLY and SETTLE and 0 in IDLE and RUN.
REQ-028 Prescaler: the counter SHALL count 0..presc and then wrap to 0; sample_tick SHALL be 1 in the cycle the counter equals presc; presc=0 SHALL give a tick every cycle.
REQ-029 sample_tick SHALL be 0 in IDLE, DISABLE and APPLY.
REQ-030 A previous-level register SHALL sample filt_out every cycle in all states.
REQ-031 Edge detection SHALL be active only in RUN: rise = filt_out & ~prev & irq_rise_en; fall = ~filt_out & prev & irq_fall_en.
REQ-032 irq_stat[i] SHALL set on a detected edge and clear on irq_clr[i]; when set and clear occur in the same cycle, set SHALL win.
REQ-033 irq SHALL be the registered-free OR of irq_stat, with no extra latency.
REQ-034 A channel with filt_en[i]=0 SHALL generate no edges.
REQ-035 All counter arithmetic SHALL be unsigned and SHALL wrap at the declared width without overflow flags.

Reset
REQ-036 On rst low, the FSM SHALL enter IDLE asynchronously.
REQ-037 On rst low, filt_en, filt_conf, sample_tick, cfg_busy, irq_stat and irq SHALL be 0, the prescaler and shadow registers SHALL be 0, and prev SHALL be all DEFAULT_OUT.
REQ-038 Reset asserted mid-sequence SHALL abort the sequence with no pending configuration retained.

Verification
REQ-039 cfg_wr with conf=3, presc=2, en=0x01 from IDLE: DISABLE for 1 cycle, APPLY for 1 cycle, sample_tick every 3rd cycle, RUN one cycle after the 3rd tick, cfg_busy high for exactly those cycles.
REQ-040 RUN with presc=0, filt_out[2] toggled 1->0 and irq_fall_en[2]=1: irq_stat[2]=1 and irq=1 in the next cycle; irq_clr[2] then clears both.
REQ-041 filt_out toggled during SETTLE: irq_stat stays 0, and no edge is reported on entering RUN.
REQ-042 A second cfg_wr during SETTLE is ignored (filt_conf unchanged); a cfg_wr in RUN with en=0 ends in IDLE with filt_en=0 and sample_tick=0.
REQ-043 Same-cycle edge and irq_clr on channel 0: irq_stat[0] remains 1.
REQ-044 rst pulsed low in SETTLE: all outputs return to 0 immediately, and the FSM restarts in IDLE.

Source files
------------

// File: rtl/input_filter_ctrl.sv
// input_filter_ctrl: reconfiguration sequencer, sample prescaler and edge
// interrupt collector for a bank of NUM_CH digital input filters.
// A configuration write is staged in shadow registers, the filters are
// briefly disabled, the new window/prescaler is applied, and the block
// waits for filt_conf sample ticks before edge reporting resumes in RUN.
module input_filter_ctrl #(
    parameter int   NUM_CH      = 8,
    parameter int   FILTER_LOG  = 4,
    parameter int   PRESC_WIDTH = 16,
    parameter logic DEFAULT_OUT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr,
    input  logic [FILTER_LOG-1:0]  cfg_conf,
    input  logic [PRESC_WIDTH-1:0] cfg_presc,
    input  logic [NUM_CH-1:0]      cfg_en,
    output logic                   cfg_busy,
    output logic [FILTER_LOG-1:0]  filt_conf,
    output logic [NUM_CH-1:0]      filt_en,
    output logic                   sample_tick,
    input  logic [NUM_CH-1:0]      filt_out,
    input  logic [NUM_CH-1:0]      irq_rise_en,
    input  logic [NUM_CH-1:0]      irq_fall_en,
    input  logic [NUM_CH-1:0]      irq_clr,
    output logic [NUM_CH-1:0]      irq_stat,
    output logic                   irq
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    state_t                   state_r;

    // Shadow copy of the last accepted configuration write
    logic [FILTER_LOG-1:0]    shd_conf_r;
    logic [PRESC_WIDTH-1:0]   shd_presc_r;
    logic [NUM_CH-1:0]        shd_en_r;

    // Active prescaler and its free-running counter
    logic [PRESC_WIDTH-1:0]   presc_r;
    logic [PRESC_WIDTH-1:0]   presc_cnt_r;
    logic [FILTER_LOG-1:0]    settle_cnt_r;

    // Registered outputs
    logic                     cfg_busy_r;
    logic [FILTER_LOG-1:0]    filt_conf_r;
    logic [NUM_CH-1:0]        filt_en_r;
    logic                     sample_tick_r;

    // Edge detection state
    logic [NUM_CH-1:0]        prev_r;
    logic [NUM_CH-1:0]        irq_stat_r;

    logic [PRESC_WIDTH-1:0]   presc_cnt_nxt_s;
    logic                     tick_nxt_s;
    logic [FILTER_LOG-1:0]    settle_cnt_inc_s;
    logic                     settle_done_s;
    logic [NUM_CH-1:0]        edge_s;

    // Prescaler wrap, next-cycle tick and settle completion decode
    always_comb begin
        presc_cnt_nxt_s  = {PRESC_WIDTH{1'b0}};
        tick_nxt_s       = 1'b0;
        settle_cnt_inc_s = settle_cnt_r + FILTER_LOG'(1);
        settle_done_s    = 1'b0;
        if (presc_cnt_r == presc_r) begin
            presc_cnt_nxt_s = {PRESC_WIDTH{1'b0}};
        end else begin
            presc_cnt_nxt_s = presc_cnt_r + PRESC_WIDTH'(1);
        end
        tick_nxt_s = (presc_cnt_nxt_s == presc_r);
        // A zero-length window settles straight away; otherwise leave on the
        // cycle after the filt_conf-th tick seen in SETTLE.
        if (filt_conf_r == {FILTER_LOG{1'b0}}) begin
            settle_done_s = 1'b1;
        end else begin
            settle_done_s = sample_tick_r && (settle_cnt_inc_s == filt_conf_r);
        end
    end

    // Reconfiguration sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            shd_conf_r    <= {FILTER_LOG{1'b0}};
            shd_presc_r   <= {PRESC_WIDTH{1'b0}};
            shd_en_r      <= {NUM_CH{1'b0}};
            presc_r       <= {PRESC_WIDTH{1'b0}};
            presc_cnt_r   <= {PRESC_WIDTH{1'b0}};
            settle_cnt_r  <= {FILTER_LOG{1'b0}};
            cfg_busy_r    <= 1'b0;
            filt_conf_r   <= {FILTER_LOG{1'b0}};
            filt_en_r     <= {NUM_CH{1'b0}};
            sample_tick_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_wr) begin
                        shd_conf_r    <= cfg_conf;
                        shd_presc_r   <= cfg_presc;
                        shd_en_r      <= cfg_en;
                        state_r       <= ST_DISABLE;
                        cfg_busy_r    <= 1'b1;
                        filt_en_r     <= {NUM_CH{1'b0}};
                        sample_tick_r <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DISABLE: begin
                    state_r <= ST_APPLY;
                end
                ST_APPLY: begin
                    filt_conf_r  <= shd_conf_r;
                    presc_r      <= shd_presc_r;
                    presc_cnt_r  <= {PRESC_WIDTH{1'b0}};
                    settle_cnt_r <= {FILTER_LOG{1'b0}};
                    if (shd_en_r != {NUM_CH{1'b0}}) begin
                        state_r       <= ST_SETTLE;
                        filt_en_r     <= shd_en_r;
                        // Counter restarts at 0, so it already equals a zero prescaler
                        sample_tick_r <= (shd_presc_r == {PRESC_WIDTH{1'b0}});
                    end else begin
                        state_r       <= ST_IDLE;
                        cfg_busy_r    <= 1'b0;
                        filt_en_r     <= {NUM_CH{1'b0}};
                        sample_tick_r <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    presc_cnt_r   <= presc_cnt_nxt_s;
                    sample_tick_r <= tick_nxt_s;
                    if (sample_tick_r) begin
                        settle_cnt_r <= settle_cnt_inc_s;
                    end else begin
                        settle_cnt_r <= settle_cnt_r;
                    end
                    if (settle_done_s) begin
                        state_r    <= ST_RUN;
                        cfg_busy_r <= 1'b0;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_RUN: begin
                    if (cfg_wr) begin
                        shd_conf_r    <= cfg_conf;
                        shd_presc_r   <= cfg_presc;
                        shd_en_r      <= cfg_en;
                        state_r       <= ST_DISABLE;
                        cfg_busy_r    <= 1'b1;
                        filt_en_r     <= {NUM_CH{1'b0}};
                        sample_tick_r <= 1'b0;
                    end else begin
                        state_r       <= ST_RUN;
                        presc_cnt_r   <= presc_cnt_nxt_s;
                        sample_tick_r <= tick_nxt_s;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    cfg_busy_r    <= 1'b0;
                    filt_en_r     <= {NUM_CH{1'b0}};
                    sample_tick_r <= 1'b0;
                end
            endcase
        end
    end

    // Edges are only reported in RUN and only on enabled filter channels
    always_comb begin
        edge_s = {NUM_CH{1'b0}};
        if (state_r == ST_RUN) begin
            edge_s = filt_en_r & ((filt_out & ~prev_r & irq_rise_en) |
                                  (~filt_out & prev_r & irq_fall_en));
        end else begin
            edge_s = {NUM_CH{1'b0}};
        end
    end

    // Previous-level tracking and sticky status; a new edge beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r     <= {NUM_CH{DEFAULT_OUT}};
            irq_stat_r <= {NUM_CH{1'b0}};
        end else begin
            prev_r     <= filt_out;
            irq_stat_r <= (irq_stat_r & ~irq_clr) | edge_s;
        end
    end

    assign cfg_busy    = cfg_busy_r;
    assign filt_conf   = filt_conf_r;
    assign filt_en     = filt_en_r;
    assign sample_tick = sample_tick_r;
    assign irq_stat    = irq_stat_r;
    assign irq         = |irq_stat_r;

endmodule

// File: tb/tb_input_filter_ctrl.sv
// Directed scoreboard bench for input_filter_ctrl (default parameters).
module tb_input_filter_ctrl;

    localparam int S_BUSY = 0;
    localparam int S_CONF = 1;
    localparam int S_EN   = 2;
    localparam int S_TICK = 3;
    localparam int S_STAT = 4;
    localparam int S_IRQ  = 5;

    logic        clk;
    logic        rst;
    logic        cfg_wr;
    logic [3:0]  cfg_conf;
    logic [15:0] cfg_presc;
    logic [7:0]  cfg_en;
    logic        cfg_busy;
    logic [3:0]  filt_conf;
    logic [7:0]  filt_en;
    logic        sample_tick;
    logic [7:0]  filt_out;
    logic [7:0]  irq_rise_en;
    logic [7:0]  irq_fall_en;
    logic [7:0]  irq_clr;
    logic [7:0]  irq_stat;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] val_q[$];

    input_filter_ctrl dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_conf(cfg_conf),
        .cfg_presc(cfg_presc), .cfg_en(cfg_en), .cfg_busy(cfg_busy),
        .filt_conf(filt_conf), .filt_en(filt_en), .sample_tick(sample_tick),
        .filt_out(filt_out), .irq_rise_en(irq_rise_en), .irq_fall_en(irq_fall_en),
        .irq_clr(irq_clr), .irq_stat(irq_stat), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            S_BUSY:  return {31'd0, cfg_busy};
            S_CONF:  return {28'd0, filt_conf};
            S_EN:    return {24'd0, filt_en};
            S_TICK:  return {31'd0, sample_tick};
            S_STAT:  return {24'd0, irq_stat};
            S_IRQ:   return {31'd0, irq};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(string tag, int sel, int val);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        val_q.push_back(32'(val));
    endtask

    // Queue expectations for one cycle; a negative value means "not checked"
    task automatic expect_cyc(string tag, int busy, int conf, int en, int tk, int stat);
        if (busy >= 0) push({tag, "/busy"}, S_BUSY, busy);
        if (conf >= 0) push({tag, "/conf"}, S_CONF, conf);
        if (en   >= 0) push({tag, "/en"},   S_EN,   en);
        if (tk   >= 0) push({tag, "/tick"}, S_TICK, tk);
        if (stat >= 0) begin
            push({tag, "/stat"}, S_STAT, stat);
            push({tag, "/irq"},  S_IRQ,  (stat != 0) ? 1 : 0);
        end
    endtask

    task automatic drain();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = val_q.pop_front();
            o = obs(s);
            checks++;
            assert (o === e) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", t, o, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b0; cfg_wr = 1'b0; cfg_conf = 4'd0; cfg_presc = 16'd0; cfg_en = 8'h00;
        filt_out = 8'hFF; irq_rise_en = 8'h00; irq_fall_en = 8'h00; irq_clr = 8'h00;

        // Reset state before any clock edge
        #3;
        expect_cyc("reset", 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        expect_cyc("idle", 0, 0, 0, 0, 0);
        step();

        // conf=3 presc=2 en=01 from IDLE; glitches and a second write during SETTLE
        irq_rise_en = 8'hFF; irq_fall_en = 8'hFF;
        cfg_wr = 1'b1; cfg_conf = 4'd3; cfg_presc = 16'd2; cfg_en = 8'h01;
        expect_cyc("dis1", 1, 0, 0, 0, 0);
        step();
        cfg_wr = 1'b0;
        expect_cyc("app1", 1, -1, -1, 0, 0);
        step();
        for (int k = 0; k < 12; k++) begin
            if (k == 3) filt_out = 8'hFE;
            if (k == 6) filt_out = 8'hFF;
            if (k == 5) begin
                cfg_wr = 1'b1; cfg_conf = 4'd7; cfg_presc = 16'd0; cfg_en = 8'h00;
            end
            if (k == 6) cfg_wr = 1'b0;
            expect_cyc($sformatf("set1_%0d", k), (k < 9) ? 1 : 0, 3, 8'h01,
                       (k % 3 == 2) ? 1 : 0, 0);
            step();
        end

        // Reconfigure from RUN: conf=1 presc=0 en=FF
        cfg_wr = 1'b1; cfg_conf = 4'd1; cfg_presc = 16'd0; cfg_en = 8'hFF;
        expect_cyc("dis2", 1, 3, 0, 0, 0);
        step();
        cfg_wr = 1'b0;
        expect_cyc("app2", 1, -1, -1, 0, 0);
        step();
        expect_cyc("set2", 1, 1, 8'hFF, 1, 0);
        step();
        expect_cyc("run2", 0, 1, 8'hFF, 1, 0);
        step();
        irq_rise_en = 8'h00; irq_fall_en = 8'h04;
        expect_cyc("run2b", 0, 1, 8'hFF, 1, 0);
        step();

        // Falling edge on channel 2, reported next cycle, then cleared
        filt_out = 8'hFB;
        expect_cyc("fall2_now", 0, 1, 8'hFF, 1, 0);
        drain();
        expect_cyc("fall2", 0, 1, 8'hFF, 1, 8'h04);
        step();
        irq_clr = 8'h04;
        expect_cyc("clr2", 0, 1, 8'hFF, 1, 0);
        step();
        irq_clr = 8'h00;

        // Channel 0: edge and clear in the same cycle, set wins
        irq_rise_en = 8'h01; irq_fall_en = 8'h01;
        filt_out = 8'hFA; irq_clr = 8'h01;
        expect_cyc("setwins", 0, 1, 8'hFF, 1, 8'h01);
        step();
        expect_cyc("clr0", 0, 1, 8'hFF, 1, 0);
        step();
        irq_clr = 8'h00;
        filt_out = 8'hFB;
        expect_cyc("rise0", 0, 1, 8'hFF, 1, 8'h01);
        step();
        irq_clr = 8'h01;
        expect_cyc("clr0b", 0, 1, 8'hFF, 1, 0);
        step();
        irq_clr = 8'h00;

        // cfg_wr in RUN with en=0 ends in IDLE; no edges reported in IDLE
        cfg_wr = 1'b1; cfg_conf = 4'd5; cfg_presc = 16'd3; cfg_en = 8'h00;
        expect_cyc("dis3", 1, 1, 0, 0, 0);
        step();
        cfg_wr = 1'b0;
        expect_cyc("app3", 1, -1, -1, 0, 0);
        step();
        expect_cyc("idle3", 0, 5, 0, 0, 0);
        step();
        irq_rise_en = 8'hFF; irq_fall_en = 8'hFF;
        filt_out = 8'h00;
        expect_cyc("idle3_noedge", 0, 5, 0, 0, 0);
        step();
        filt_out = 8'hFF;
        expect_cyc("idle3_noedge2", 0, 5, 0, 0, 0);
        step();

        // conf=2 presc=0 en=02: disabled channel 0 must not report edges
        cfg_wr = 1'b1; cfg_conf = 4'd2; cfg_presc = 16'd0; cfg_en = 8'h02;
        expect_cyc("dis4", 1, 5, 0, 0, 0);
        step();
        cfg_wr = 1'b0;
        expect_cyc("app4", 1, -1, -1, 0, 0);
        step();
        expect_cyc("set4_0", 1, 2, 8'h02, 1, 0);
        step();
        expect_cyc("set4_1", 1, 2, 8'h02, 1, 0);
        step();
        expect_cyc("run4", 0, 2, 8'h02, 1, 0);
        step();
        filt_out = 8'hFE;
        expect_cyc("ch0_off", 0, 2, 8'h02, 1, 0);
        step();
        filt_out = 8'hFC;
        expect_cyc("ch1_fall", 0, 2, 8'h02, 1, 8'h02);
        step();

        // conf=4 presc=1 en=03, then reset asserted in SETTLE
        cfg_wr = 1'b1; cfg_conf = 4'd4; cfg_presc = 16'd1; cfg_en = 8'h03;
        expect_cyc("dis5", 1, 2, 0, 0, 8'h02);
        step();
        cfg_wr = 1'b0;
        expect_cyc("app5", 1, -1, -1, 0, 8'h02);
        step();
        expect_cyc("set5_0", 1, 4, 8'h03, 0, 8'h02);
        step();
        expect_cyc("set5_1", 1, 4, 8'h03, 1, 8'h02);
        step();
        #2;
        rst = 1'b0;
        #1;
        expect_cyc("rst_mid", 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        expect_cyc("post_rst0", 0, 0, 0, 0, 0);
        step();
        expect_cyc("post_rst1", 0, 0, 0, 0, 0);
        step();
        expect_cyc("post_rst2", 0, 0, 0, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
